// File: rtl/pong_pkg.sv
// Shared definitions for the pong engine: FSM state encoding, direction bits
// and the width helpers used to size coordinate, score and counter fields.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // Bits needed to address positions 0..extent-1.
  function automatic int unsigned coord_w(input int unsigned extent);
    return (extent > 1) ? $clog2(extent) : 1;
  endfunction

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned count_w(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: moves PAD_STEP per enabled cycle on a single pressed button,
// clamped to the field; holds when both or neither button is pressed.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned  H        = 120,
  parameter int unsigned  PAD_LEN  = 32,
  parameter int unsigned  PAD_STEP = 1,
  localparam int unsigned YW       = coord_w(H)
) (
  input  logic          GAME_CLK,
  input  logic          reset_n,
  input  logic          en,
  input  logic          up,
  input  logic          dn,
  output logic [YW-1:0] y
);

  localparam logic [YW:0]   Y_MAX = (YW+1)'(H - PAD_LEN);
  localparam logic [YW:0]   STEP  = (YW+1)'(PAD_STEP);
  localparam logic [YW-1:0] Y_RST = YW'((H - PAD_LEN) / 2);

  logic [YW-1:0] y_q, y_d;
  logic [YW:0]   y_ext;

  // Next position, widened one bit so neither clamp can wrap.
  always_comb begin
    y_d   = y_q;
    y_ext = {1'b0, y_q};
    if (en && up && !dn) begin
      y_d = (y_ext <= STEP) ? '0 : YW'(y_ext - STEP);
    end else if (en && dn && !up) begin
      y_d = ((y_ext + STEP) >= Y_MAX) ? YW'(Y_MAX) : YW'(y_ext + STEP);
    end
  end

  always_ff @(posedge GAME_CLK or negedge reset_n) begin
    if (!reset_n) begin
      y_q <= Y_RST;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: ball kinematics, two paddles, scoring and the
// serve/play/point/game-over FSM. Define PONG_COM_AI_EN to let p1 track the ball.
module pong_engine
  import pong_pkg::*;
#(
  parameter int unsigned  W            = 160,
  parameter int unsigned  H            = 120,
  parameter int unsigned  BLOCK        = 4,
  parameter int unsigned  PAD_LEN      = 32,
  parameter int unsigned  PAD_STEP     = 1,
  parameter int unsigned  MAX_SPEED    = 3,
  parameter int unsigned  WIN_SCORE    = 10,
  parameter int unsigned  SERVE_CYCLES = 60,
  localparam int unsigned XW           = coord_w(W),
  localparam int unsigned YW           = coord_w(H),
  localparam int unsigned SW           = count_w(WIN_SCORE)
) (
  input  logic          GAME_CLK,
  input  logic          reset_n,
  input  logic          start,
  input  logic          p0_up,
  input  logic          p0_dn,
  input  logic          p1_up,
  input  logic          p1_dn,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y,
  output logic [YW-1:0] p0_y,
  output logic [YW-1:0] p1_y,
  output logic [SW-1:0] p0_score,
  output logic [SW-1:0] p1_score,
  output logic [2:0]    state,
  output logic          winner,
  output logic          hit,
  output logic          goal
);

  localparam int unsigned VW = count_w(MAX_SPEED);
  localparam int unsigned CW = count_w(SERVE_CYCLES);

  localparam logic [XW-1:0] X_CTR   = XW'(W / 2 - BLOCK / 2);
  localparam logic [YW-1:0] Y_CTR   = YW'(H / 2 - BLOCK / 2);
  localparam logic [XW:0]   X_BLK   = (XW+1)'(BLOCK);
  localparam logic [XW:0]   X_HIT_R = (XW+1)'(W - 2 * BLOCK);
  localparam logic [XW:0]   X_OUT_R = (XW+1)'(W - BLOCK);
  localparam logic [YW:0]   Y_BOT   = (YW+1)'(H - BLOCK);
  localparam logic [YW:0]   Y_BLK   = (YW+1)'(BLOCK);
  localparam logic [YW:0]   Y_PAD   = (YW+1)'(PAD_LEN);
  localparam logic [VW-1:0] V_ONE   = VW'(1);
  localparam logic [VW-1:0] V_MAX   = VW'(MAX_SPEED);
  localparam logic [CW-1:0] C_LAST  = CW'(SERVE_CYCLES - 1);
  localparam logic [SW-1:0] S_WIN   = SW'(WIN_SCORE);

  state_e        state_q, state_d;
  logic [XW-1:0] ball_x_q, ball_x_d;
  logic [YW-1:0] ball_y_q, ball_y_d;
  logic          dx_q, dx_d;
  logic          dy_q, dy_d;
  logic [VW-1:0] speed_q, speed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] p0_score_q, p0_score_d;
  logic [SW-1:0] p1_score_q, p1_score_d;
  logic          winner_q, winner_d;
  logic          scorer_q, scorer_d;
  logic          hit_q, hit_d;
  logic          goal_q, goal_d;
  logic          enter_serve;

  logic          paddle_en;
  logic          p1_up_c, p1_dn_c;

  assign paddle_en = (state_q == SERVE) || (state_q == PLAY);

`ifdef PONG_COM_AI_EN
  logic [YW:0] ball_mid, pad_mid;
  logic        ai_unused;

  assign ai_unused = p1_up | p1_dn;
  assign ball_mid  = {1'b0, ball_y_q} + (YW+1)'(BLOCK / 2);
  assign pad_mid   = {1'b0, p1_y} + (YW+1)'(PAD_LEN / 2);
  assign p1_up_c   = ball_mid < pad_mid;
  assign p1_dn_c   = ball_mid > pad_mid;
`else
  assign p1_up_c = p1_up;
  assign p1_dn_c = p1_dn;
`endif

  paddle_ctrl #(.H(H), .PAD_LEN(PAD_LEN), .PAD_STEP(PAD_STEP)) u_pad0 (
    .GAME_CLK (GAME_CLK),
    .reset_n  (reset_n),
    .en       (paddle_en),
    .up       (p0_up),
    .dn       (p0_dn),
    .y        (p0_y)
  );

  paddle_ctrl #(.H(H), .PAD_LEN(PAD_LEN), .PAD_STEP(PAD_STEP)) u_pad1 (
    .GAME_CLK (GAME_CLK),
    .reset_n  (reset_n),
    .en       (paddle_en),
    .up       (p1_up_c),
    .dn       (p1_dn_c),
    .y        (p1_y)
  );

  logic [XW:0]   xe, sx, kin_x;
  logic [YW:0]   ye, sy, kin_y;
  logic          kin_dx, kin_dy, kin_hit, kin_miss, kin_scorer;
  logic          p0_ov, p1_ov;
  logic [VW-1:0] kin_speed, speed_up;

  // One ball step at the current speed, widened one bit against wrap-around.
  always_comb begin
    xe         = {1'b0, ball_x_q};
    ye         = {1'b0, ball_y_q};
    sx         = (XW+1)'(speed_q);
    sy         = (YW+1)'(speed_q);
    p0_ov      = ((ye + Y_BLK) > {1'b0, p0_y}) && (ye < ({1'b0, p0_y} + Y_PAD));
    p1_ov      = ((ye + Y_BLK) > {1'b0, p1_y}) && (ye < ({1'b0, p1_y} + Y_PAD));
    speed_up   = (speed_q >= V_MAX) ? V_MAX : speed_q + V_ONE;
    kin_x      = xe;
    kin_y      = ye;
    kin_dx     = dx_q;
    kin_dy     = dy_q;
    kin_speed  = speed_q;
    kin_hit    = 1'b0;
    kin_miss   = 1'b0;
    kin_scorer = 1'b0;

    if (dy_q == DIR_DOWN) begin
      if ((ye + sy) >= Y_BOT) begin
        kin_y  = Y_BOT;
        kin_dy = DIR_UP;
      end else begin
        kin_y = ye + sy;
      end
    end else begin
      if (ye <= sy) begin
        kin_y  = '0;
        kin_dy = DIR_DOWN;
      end else begin
        kin_y = ye - sy;
      end
    end

    if (dx_q == DIR_LEFT) begin
      if (xe <= (sx + X_BLK)) begin
        if (p0_ov) begin
          kin_x     = X_BLK;
          kin_dx    = DIR_RIGHT;
          kin_speed = speed_up;
          kin_hit   = 1'b1;
        end else begin
          kin_x      = '0;
          kin_miss   = 1'b1;
          kin_scorer = 1'b1;
        end
      end else begin
        kin_x = xe - sx;
      end
    end else begin
      if ((xe + sx) >= X_HIT_R) begin
        if (p1_ov) begin
          kin_x     = X_HIT_R;
          kin_dx    = DIR_LEFT;
          kin_speed = speed_up;
          kin_hit   = 1'b1;
        end else begin
          kin_x      = X_OUT_R;
          kin_miss   = 1'b1;
          kin_scorer = 1'b0;
        end
      end else begin
        kin_x = xe + sx;
      end
    end
  end

  // Game FSM and registered output updates.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    speed_d     = speed_q;
    cnt_d       = cnt_q;
    p0_score_d  = p0_score_q;
    p1_score_d  = p1_score_q;
    winner_d    = winner_q;
    scorer_d    = scorer_q;
    hit_d       = 1'b0;
    goal_d      = 1'b0;
    enter_serve = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          enter_serve = 1'b1;
          dx_d        = DIR_RIGHT;
        end
      end
      SERVE: begin
        if (cnt_q == C_LAST) begin
          state_d  = PLAY;
          ball_x_d = XW'(kin_x);
          ball_y_d = YW'(kin_y);
          dx_d     = kin_dx;
          dy_d     = kin_dy;
          speed_d  = kin_speed;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PLAY: begin
        ball_x_d = XW'(kin_x);
        ball_y_d = YW'(kin_y);
        dx_d     = kin_dx;
        dy_d     = kin_dy;
        speed_d  = kin_speed;
        hit_d    = kin_hit;
        if (kin_miss) begin
          state_d  = POINT;
          goal_d   = 1'b1;
          scorer_d = kin_scorer;
          if (kin_scorer) begin
            p1_score_d = p1_score_q + SW'(1);
          end else begin
            p0_score_d = p0_score_q + SW'(1);
          end
        end
      end
      POINT: begin
        if (scorer_q ? (p1_score_q == S_WIN) : (p0_score_q == S_WIN)) begin
          state_d  = GAMEOVER;
          winner_d = scorer_q;
        end else begin
          enter_serve = 1'b1;
          dx_d        = scorer_q ? DIR_LEFT : DIR_RIGHT;
        end
      end
      GAMEOVER: begin
        if (start) begin
          enter_serve = 1'b1;
          dx_d        = DIR_RIGHT;
          p0_score_d  = '0;
          p1_score_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every serve starts from the centre at base speed; dy carries over.
    if (enter_serve) begin
      state_d  = SERVE;
      ball_x_d = X_CTR;
      ball_y_d = Y_CTR;
      speed_d  = V_ONE;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge GAME_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ball_x_q   <= X_CTR;
      ball_y_q   <= Y_CTR;
      dx_q       <= DIR_RIGHT;
      dy_q       <= DIR_DOWN;
      speed_q    <= V_ONE;
      cnt_q      <= '0;
      p0_score_q <= '0;
      p1_score_q <= '0;
      winner_q   <= 1'b0;
      scorer_q   <= 1'b0;
      hit_q      <= 1'b0;
      goal_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      p0_score_q <= p0_score_d;
      p1_score_q <= p1_score_d;
      winner_q   <= winner_d;
      scorer_q   <= scorer_d;
      hit_q      <= hit_d;
      goal_q     <= goal_d;
    end
  end

  assign ball_x   = ball_x_q;
  assign ball_y   = ball_y_q;
  assign p0_score = p0_score_q;
  assign p1_score = p1_score_q;
  assign state    = state_q;
  assign winner   = winner_q;
  assign hit      = hit_q;
  assign goal     = goal_q;

endmodule
